add_accumulator: RTL

Streaming accumulator that sits directly downstream of the team's ripple-carry adder. It instantiates `rca` as its sum datapath and adds a stream of WIDTH-bit operands into a running total. The stream is framed by a last flag. When the frame closes, the block presents the wrapped sum, the number of carry-outs, and the operand count on a valid/ready result port.

---
 rtl/add_accumulator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/add_accumulator.sv
// Streaming frame accumulator: sums a last-framed operand stream through a ripple-carry
// adder and presents sum, carry count and operand count on a valid/ready result port.

module rca #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             c
);

   // Carry is walked as a local variable so the chain stays a single combinational pass.
   always_comb begin
      logic cy;
      s  = '0;
      cy = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         s[i] = a[i] ^ b[i] ^ cy;
         cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
      c = cy;
   end

endmodule

module add_accumulator #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_sum,
   output logic [CNT_WIDTH-1:0] out_carries,
   output logic [CNT_WIDTH-1:0] out_count
);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     acc_sum_q, acc_sum_d;
   logic [CNT_WIDTH-1:0] carries_q, carries_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic [WIDTH-1:0]     rca_s;
   logic                 rca_c;
   logic                 accept;
   logic                 handshake;

   rca #(.WIDTH(WIDTH)) u_rca (
      .a (acc_sum_q),
      .b (in_data),
      .s (rca_s),
      .c (rca_c)
   );

   // Handshakes are qualified by the registered state only, never by each other.
   assign accept    = in_valid  && (state_q == ST_ACC);
   assign handshake = out_ready && (state_q == ST_HOLD);

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_ACC;
      end else begin
         unique case (state_q)
            ST_ACC:  if (accept && in_last) state_d = ST_HOLD;
            ST_HOLD: if (handshake)         state_d = ST_ACC;
            default:                        state_d = ST_ACC;
         endcase
      end
   end

   always_comb begin
      acc_sum_d = acc_sum_q;
      carries_d = carries_q;
      count_d   = count_q;
      if (clear || handshake) begin
         acc_sum_d = '0;
         carries_d = '0;
         count_d   = '0;
      end else if (accept) begin
         acc_sum_d = rca_s;
         if (carries_q != CNT_MAX) carries_d = carries_q + CNT_WIDTH'(rca_c);
         if (count_q != CNT_MAX)   count_d   = count_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ACC;
         acc_sum_q <= '0;
         carries_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         acc_sum_q <= acc_sum_d;
         carries_q <= carries_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      in_ready    = (state_q == ST_ACC);
      out_valid   = (state_q == ST_HOLD);
      out_sum     = acc_sum_q;
      out_carries = carries_q;
      out_count   = count_q;
   end

endmodule
